// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode classes, multiply opcodes, flag bit positions
// and the skid buffer state encoding.
package alu_pkg;

  localparam logic [2:0] ARITH = 3'b000;
  localparam logic [2:0] LOGIC = 3'b001;
  localparam logic [2:0] SHIFT = 3'b010;
  localparam logic [2:0] LDST  = 3'b011;

  localparam logic [6:0] OP_MULT  = 7'b0000010;
  localparam logic [6:0] OP_MULTU = 7'b0000001;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_O = 1;
  localparam int FLAG_S = 0;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_FULL1,
    SKID_FULL2
  } skid_state_t;

  function automatic logic is_mult(input logic [6:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  // Address generation and undefined classes must not disturb the branch flags.
  function automatic logic class_sets_flags(input logic [2:0] op_class);
    return (op_class == ARITH) || (op_class == LOGIC) || (op_class == SHIFT);
  endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// Two-entry valid/ready skid buffer; in_ready is a decode of the state register,
// so the producer never sees a combinational path from out_ready.
module wb_skid_buffer
  import alu_pkg::*;
#(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state;
  skid_state_t  state_next;
  logic [W-1:0] m_data;
  logic [W-1:0] s_data;
  logic         load_m_in;
  logic         load_m_s;
  logic         load_s;
  logic         accept;
  logic         emit;

  assign in_ready  = (state != SKID_FULL2);
  assign out_valid = (state != SKID_EMPTY);
  assign out_data  = m_data;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_comb begin
    state_next = state;
    load_m_in  = 1'b0;
    load_m_s   = 1'b0;
    load_s     = 1'b0;
    case (state)
      SKID_EMPTY: begin
        if (accept) begin
          load_m_in  = 1'b1;
          state_next = SKID_FULL1;
        end
      end
      SKID_FULL1: begin
        if (accept && emit) begin
          load_m_in = 1'b1;
        end else if (accept) begin
          load_s     = 1'b1;
          state_next = SKID_FULL2;
        end else if (emit) begin
          state_next = SKID_EMPTY;
        end
      end
      SKID_FULL2: begin
        if (emit) begin
          load_m_s   = 1'b1;
          state_next = SKID_FULL1;
        end
      end
      default: state_next = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SKID_EMPTY;
      m_data <= '0;
      s_data <= '0;
    end else begin
      state <= state_next;
      if (load_m_in) begin
        m_data <= in_data;
      end else if (load_m_s) begin
        m_data <= s_data;
      end
      if (load_s) begin
        s_data <= in_data;
      end else if (load_m_s) begin
        s_data <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// Registered stage after the ALU: architectural HI/LO/FLAGS plus a skid-buffered
// writeback path carrying {result, rd, we} to the register file.
module alu_writeback_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int OP_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_alu_op,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_hi,
  input  logic [DATA_W-1:0] in_lo,
  input  logic              in_zf,
  input  logic              in_cf,
  input  logic              in_of,
  input  logic              in_sf,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_we,
  output logic [DATA_W-1:0] hi_reg,
  output logic [DATA_W-1:0] lo_reg,
  output logic [3:0]        flags
);

  localparam int PAY_W = DATA_W + REG_W + 1;

  logic             accept;
  logic             mult_op;
  logic             flags_op;
  logic             m_we;
  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] pay_out;

  assign accept   = in_valid & in_ready;
  assign mult_op  = is_mult(in_alu_op);
  assign flags_op = class_sets_flags(in_alu_op[OP_W-1 -: 3]);

  // Multiplies only target HI/LO, but still travel the queue to keep ordering.
  assign pay_in = {in_result, in_rd, in_we & ~mult_op};

  wb_skid_buffer #(
    .W(PAY_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (pay_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (pay_out)
  );

  assign {out_result, out_rd, m_we} = pay_out;
  assign out_we = m_we & out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
      flags  <= '0;
    end else if (accept) begin
      if (mult_op) begin
        hi_reg <= in_hi;
        lo_reg <= in_lo;
      end
      if (flags_op) begin
        flags[FLAG_Z] <= in_zf;
        flags[FLAG_C] <= in_cf;
        flags[FLAG_O] <= in_of;
        flags[FLAG_S] <= in_sf;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: expected {result,rd,we} entries are
// queued on accept and popped on emit; HI/LO/FLAGS follow a small accept-time model.
module tb_alu_writeback_stage;

  localparam logic [6:0] OP_ADD   = 7'b0000000;
  localparam logic [6:0] OP_XOR   = 7'b0010011;
  localparam logic [6:0] OP_SLL   = 7'b0100000;
  localparam logic [6:0] OP_LDST  = 7'b0110000;
  localparam logic [6:0] OP_MUL   = 7'b0000010;
  localparam logic [6:0] OP_MULU  = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_alu_op = '0;
  logic [31:0] in_result = '0;
  logic [31:0] in_hi = '0;
  logic [31:0] in_lo = '0;
  logic        in_zf = 1'b0;
  logic        in_cf = 1'b0;
  logic        in_of = 1'b0;
  logic        in_sf = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_we = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [3:0]  flags;

  int compared = 0;
  int mismatched = 0;

  logic [37:0] sb[$];
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [3:0]  exp_flags = '0;

  alu_writeback_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_alu_op (in_alu_op),
    .in_result (in_result),
    .in_hi     (in_hi),
    .in_lo     (in_lo),
    .in_zf     (in_zf),
    .in_cf     (in_cf),
    .in_of     (in_of),
    .in_sf     (in_sf),
    .in_rd     (in_rd),
    .in_we     (in_we),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_rd    (out_rd),
    .out_we    (out_we),
    .hi_reg    (hi_reg),
    .lo_reg    (lo_reg),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Drives one cycle starting at a negedge and returns at the next negedge.
  // Handshake outcome is predicted from the registered in_ready/out_valid.
  task automatic drive_cycle(input logic v, input logic [6:0] op, input logic [31:0] res,
                             input logic [31:0] hi, input logic [31:0] lo, input logic [3:0] fl,
                             input logic [4:0] rd, input logic we, input logic rdy,
                             output logic acc, output logic emit,
                             output logic [37:0] obs, output logic [37:0] exp);
    logic is_m;
    in_valid = v; in_alu_op = op; in_result = res; in_hi = hi; in_lo = lo;
    {in_zf, in_cf, in_of, in_sf} = fl;
    in_rd = rd; in_we = we; out_ready = rdy;
    #1;
    acc  = v && (in_ready === 1'b1);
    emit = (out_valid === 1'b1) && rdy;
    obs  = {out_result, out_rd, out_we};
    exp  = ~obs;
    if (emit && sb.size() > 0) exp = sb.pop_front();
    if (acc) begin
      is_m = (op == OP_MUL) || (op == OP_MULU);
      sb.push_back({res, rd, we && !is_m});
      if (is_m) begin
        exp_hi = hi;
        exp_lo = lo;
      end
      if (op[6:4] == 3'b000 || op[6:4] == 3'b001 || op[6:4] == 3'b010) exp_flags = fl;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete(); exp_hi = '0; exp_lo = '0; exp_flags = '0;
    compared++;
    if ({out_valid, in_ready, out_we} !== 3'b010) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got {ov,ir,we}=%b, expected 010", {out_valid, in_ready, out_we});
    end
    compared++;
    if ({hi_reg, lo_reg, flags, out_result, out_rd} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_regs: got hi=%h lo=%h flags=%b res=%h rd=%h, expected all 0",
               hi_reg, lo_reg, flags, out_result, out_rd);
    end
  endtask

  task automatic test_back_to_back();
    logic acc, emit;
    logic [37:0] obs, exp;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(i < 3, OP_ADD, 32'(5 + i), '0, '0, 4'b0000, 5'(i + 1), 1'b1, 1'b1,
                  acc, emit, obs, exp);
      compared++;
      if (emit !== (i != 0)) begin
        mismatched++;
        $display("[TB] FAIL b2b_latency[%0d]: got emit=%b, expected %b", i, emit, i != 0);
      end
      if (i != 0) begin
        compared++;
        if (obs !== exp || obs[37:6] !== 32'(4 + i) || obs[0] !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL b2b_data[%0d]: got %h, expected %h (result %0d, we 1)", i, obs, exp, 4 + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic acc, emit;
    logic [37:0] obs, exp;
    logic [31:0] got[$];
    logic c_pending;
    drive_cycle(1'b1, OP_ADD, 32'h11, '0, '0, 4'b0000, 5'd1, 1'b1, 1'b0, acc, emit, obs, exp);
    drive_cycle(1'b1, OP_ADD, 32'h22, '0, '0, 4'b0000, 5'd2, 1'b1, 1'b0, acc, emit, obs, exp);
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bp_in_ready: got %b, expected 0", in_ready);
    end
    drive_cycle(1'b1, OP_ADD, 32'h33, '0, '0, 4'b0000, 5'd3, 1'b1, 1'b0, acc, emit, obs, exp);
    compared++;
    if (acc !== 1'b0 || emit !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bp_hold: got acc=%b emit=%b, expected 0 0", acc, emit);
    end
    c_pending = !acc;
    for (int i = 0; i < 8 && (c_pending || sb.size() > 0); i++) begin
      drive_cycle(c_pending, OP_ADD, 32'h33, '0, '0, 4'b0000, 5'd3, 1'b1, 1'b1, acc, emit, obs, exp);
      if (acc) c_pending = 1'b0;
      if (emit) begin
        got.push_back(obs[37:6]);
        compared++;
        if (obs !== exp) begin
          mismatched++;
          $display("[TB] FAIL bp_data: got %h, expected %h", obs, exp);
        end
      end
    end
    compared++;
    if (got.size() != 3 || got[0] !== 32'h11 || got[1] !== 32'h22 || got[2] !== 32'h33) begin
      mismatched++;
      $display("[TB] FAIL bp_order: got %0d entries, expected 11,22,33", got.size());
    end
  endtask

  task automatic test_multiply();
    logic acc, emit;
    logic [37:0] obs, exp;
    drive_cycle(1'b1, OP_MUL, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0000, 5'd4, 1'b1, 1'b1,
                acc, emit, obs, exp);
    compared++;
    if (hi_reg !== 32'hFFFFFFFF || lo_reg !== 32'hFFFFFFFE) begin
      mismatched++;
      $display("[TB] FAIL mult_hilo: got hi=%h lo=%h, expected ffffffff fffffffe", hi_reg, lo_reg);
    end
    drive_cycle(1'b1, OP_ADD, 32'd9, 32'h12345678, 32'h9ABCDEF0, 4'b0000, 5'd5, 1'b1, 1'b1,
                acc, emit, obs, exp);
    compared++;
    if (emit !== 1'b1 || obs !== exp || obs[0] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mult_we: got emit=%b %h, expected emit=1 %h with we 0", emit, obs, exp);
    end
    compared++;
    if (hi_reg !== 32'hFFFFFFFF || lo_reg !== 32'hFFFFFFFE) begin
      mismatched++;
      $display("[TB] FAIL add_keeps_hilo: got hi=%h lo=%h, expected ffffffff fffffffe", hi_reg, lo_reg);
    end
    drive_cycle(1'b0, OP_ADD, '0, '0, '0, 4'b0000, 5'd0, 1'b0, 1'b1, acc, emit, obs, exp);
    compared++;
    if (emit !== 1'b1 || obs !== exp || obs[0] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mult_follow_add: got %h, expected %h", obs, exp);
    end
  endtask

  task automatic test_flags();
    logic acc, emit;
    logic [37:0] obs, exp;
    logic [6:0]  ops[3];
    logic [3:0]  fl_in[3];
    logic [3:0]  fl_want[3];
    ops = '{OP_XOR, OP_LDST, OP_ADD};
    fl_in = '{4'b1000, 4'b0000, 4'b0001};
    fl_want = '{4'b1000, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(i < 3, (i < 3) ? ops[i] : OP_ADD, 32'(i), '0, '0, (i < 3) ? fl_in[i] : 4'b0000,
                  5'(i + 8), 1'b1, 1'b1, acc, emit, obs, exp);
      if (i < 3) begin
        compared++;
        if (flags !== fl_want[i]) begin
          mismatched++;
          $display("[TB] FAIL flags[%0d]: got %b, expected %b", i, flags, fl_want[i]);
        end
      end
      if (emit) begin
        compared++;
        if (obs !== exp) begin
          mismatched++;
          $display("[TB] FAIL flags_data[%0d]: got %h, expected %h", i, obs, exp);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic acc, emit;
    logic [37:0] obs, exp;
    logic        pend;
    logic [6:0]  p_op;
    logic [31:0] p_res, p_hi, p_lo;
    logic [3:0]  p_fl;
    logic [4:0]  p_rd;
    logic        p_we;
    drive_cycle(1'b1, OP_ADD, 32'hA1, '0, '0, 4'b0000, 5'd1, 1'b1, 1'b0, acc, emit, obs, exp);
    drive_cycle(1'b1, OP_SLL, 32'hB2, '0, '0, 4'b0100, 5'd2, 1'b1, 1'b1, acc, emit, obs, exp);
    compared++;
    if (acc !== 1'b1 || emit !== 1'b1 || obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL simul_handshake: got acc=%b emit=%b %h, expected 1 1 %h", acc, emit, obs, exp);
    end
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_result !== 32'hB2) begin
      mismatched++;
      $display("[TB] FAIL simul_full1: got ir=%b ov=%b res=%h, expected 1 1 b2", in_ready, out_valid, out_result);
    end
    pend = 1'b0;
    p_op = OP_ADD; p_res = '0; p_hi = '0; p_lo = '0; p_fl = '0; p_rd = '0; p_we = 1'b0;
    for (int i = 0; i < 110; i++) begin
      if (!pend && i < 100 && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        case ($urandom_range(0, 4))
          0: p_op = OP_ADD;
          1: p_op = OP_XOR;
          2: p_op = OP_LDST;
          3: p_op = OP_MUL;
          default: p_op = OP_MULU;
        endcase
        p_res = $urandom; p_hi = $urandom; p_lo = $urandom;
        p_fl = 4'($urandom); p_rd = 5'($urandom); p_we = 1'($urandom);
      end
      drive_cycle(pend, p_op, p_res, p_hi, p_lo, p_fl, p_rd, p_we,
                  (i >= 100) || ($urandom_range(0, 2) != 0), acc, emit, obs, exp);
      if (acc) pend = 1'b0;
      if (emit) begin
        compared++;
        if (obs !== exp) begin
          mismatched++;
          $display("[TB] FAIL random_order[%0d]: got %h, expected %h", i, obs, exp);
        end
      end
    end
    compared++;
    if (sb.size() != 0 || out_valid !== 1'b0 || pend) begin
      mismatched++;
      $display("[TB] FAIL random_drain: got %0d left, ov=%b, expected 0 left, ov=0", sb.size(), out_valid);
    end
    compared++;
    if (hi_reg !== exp_hi || lo_reg !== exp_lo || flags !== exp_flags) begin
      mismatched++;
      $display("[TB] FAIL random_arch: got hi=%h lo=%h fl=%b, expected %h %h %b",
               hi_reg, lo_reg, flags, exp_hi, exp_lo, exp_flags);
    end
  endtask

  task automatic test_reset_mid();
    logic acc, emit;
    logic [37:0] obs, exp;
    drive_cycle(1'b1, OP_MUL, 32'h1, 32'hDEAD, 32'hBEEF, 4'b0110, 5'd6, 1'b1, 1'b0, acc, emit, obs, exp);
    drive_cycle(1'b1, OP_ADD, 32'h2, '0, '0, 4'b1111, 5'd7, 1'b1, 1'b0, acc, emit, obs, exp);
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rstmid_full2: got in_ready=%b, expected 0", in_ready);
    end
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || hi_reg !== '0 || lo_reg !== '0 || flags !== '0) begin
      mismatched++;
      $display("[TB] FAIL rstmid_state: got ov=%b ir=%b hi=%h lo=%h fl=%b, expected 0 1 0 0 0",
               out_valid, in_ready, hi_reg, lo_reg, flags);
    end
    rst = 1'b0;
    sb.delete(); exp_hi = '0; exp_lo = '0; exp_flags = '0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, OP_ADD, '0, '0, '0, 4'b0000, 5'd0, 1'b0, 1'b1, acc, emit, obs, exp);
      compared++;
      if (emit !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL rstmid_no_write[%0d]: got emit=%b res=%h, expected no writeback", i, emit, obs[37:6]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_multiply();
    test_flags();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
